// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional alignment checking is enabled by defining IFETCH_ALIGN_CHECK_EN.
package ifetch_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } ifetch_state_e;

  localparam logic [31:0] NopInstr         = 32'h0000_0000;
  localparam logic [31:0] PcResetDefault   = 32'h0000_0000;
  localparam logic [31:0] IntVectorDefault = 32'h0000_0800;

  // True when the low two bits would make a word fetch misaligned.
  function automatic logic is_misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux for the fetch stage: halt > eret > interrupt > redirect > stall > fetch.
// With IFETCH_ALIGN_CHECK_EN defined, misaligned redirect/eret targets halt the stage.
module pc_next_sel
  import ifetch_pkg::*;
#(
  parameter int unsigned        PC_BITS    = 32,
  parameter logic [PC_BITS-1:0] INT_VECTOR = PC_BITS'(IntVectorDefault)
) (
  input  logic               run_i,
  input  logic [PC_BITS-1:0] pc_i,
  input  logic [PC_BITS-1:0] epc_i,
  input  logic               in_isr_i,
  input  logic               stall_i,
  input  logic               redirect_valid_i,
  input  logic [PC_BITS-1:0] redirect_pc_i,
  input  logic               int_req_i,
  input  logic               eret_i,
  input  logic               halt_req_i,
  output logic [PC_BITS-1:0] pc_d_o,
  output logic               epc_we_o,
  output logic [PC_BITS-1:0] epc_d_o,
  output logic               squash_o,
  output logic               fetch_o,
  output logic               int_take_o,
  output logic               isr_clr_o,
  output logic               halt_o,
  output logic               align_err_o
);

`ifdef IFETCH_ALIGN_CHECK_EN
  localparam bit AlignCheck = 1'b1;
`else
  localparam bit AlignCheck = 1'b0;
`endif

  logic eret_bad, redir_bad;
  assign eret_bad  = AlignCheck && is_misaligned(epc_i[1:0]);
  assign redir_bad = AlignCheck && is_misaligned(redirect_pc_i[1:0]);

  // Resolve this cycle's control action in priority order; only active in RUN.
  always_comb begin
    pc_d_o      = pc_i;
    epc_we_o    = 1'b0;
    epc_d_o     = pc_i;
    squash_o    = 1'b0;
    fetch_o     = 1'b0;
    int_take_o  = 1'b0;
    isr_clr_o   = 1'b0;
    halt_o      = 1'b0;
    align_err_o = 1'b0;
    if (run_i) begin
      if (halt_req_i) begin
        halt_o = 1'b1;
      end else if (eret_i) begin
        if (eret_bad) begin
          halt_o      = 1'b1;
          align_err_o = 1'b1;
        end else begin
          pc_d_o    = epc_i;
          isr_clr_o = 1'b1;
          squash_o  = 1'b1;
        end
      end else if (int_req_i && !in_isr_i && !stall_i) begin
        // A same-cycle redirect is the instruction stream we must return to.
        int_take_o = 1'b1;
        epc_we_o   = 1'b1;
        epc_d_o    = redirect_valid_i ? redirect_pc_i : pc_i;
        pc_d_o     = INT_VECTOR;
        squash_o   = 1'b1;
      end else if (redirect_valid_i) begin
        if (redir_bad) begin
          halt_o      = 1'b1;
          align_err_o = 1'b1;
        end else begin
          pc_d_o   = redirect_pc_i;
          squash_o = 1'b1;
        end
      end else if (!stall_i) begin
        fetch_o = 1'b1;
        pc_d_o  = pc_i + PC_BITS'(4);
      end
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the combinational ROM and fills the IF/ID register.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned redirect/eret targets into HALT with addr_err.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned        PC_BITS       = 32,
  parameter int unsigned        ROM_ADDR_BITS = 10,
  parameter logic [PC_BITS-1:0] PC_RESET      = PC_BITS'(PcResetDefault),
  parameter logic [PC_BITS-1:0] INT_VECTOR    = PC_BITS'(IntVectorDefault)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [PC_BITS-1:0]       redirect_pc,
  input  logic                     int_req,
  input  logic                     eret,
  input  logic                     halt_req,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  output logic                     rom_sel,
  input  logic [31:0]              rom_dout,
  output logic                     id_valid,
  output logic [PC_BITS-1:0]       id_pc,
  output logic [31:0]              id_instr,
  output logic                     int_ack,
  output logic                     in_isr,
  output logic [PC_BITS-1:0]       epc,
  output logic                     addr_err
);

  ifetch_state_e      state_q, state_d;
  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [PC_BITS-1:0] epc_q, epc_d;
  logic [PC_BITS-1:0] id_pc_q, id_pc_d;
  logic [31:0]        id_instr_q, id_instr_d;
  logic               id_valid_q, id_valid_d;
  logic               in_isr_q, in_isr_d;
  logic               addr_err_q, addr_err_d;

  logic               run;
  logic [PC_BITS-1:0] sel_pc_d, sel_epc_d;
  logic               sel_epc_we, sel_squash, sel_fetch, sel_int_take;
  logic               sel_isr_clr, sel_halt, sel_align_err;

  assign run = (state_q == StRun);

  pc_next_sel #(
    .PC_BITS    (PC_BITS),
    .INT_VECTOR (INT_VECTOR)
  ) u_pc_next_sel (
    .run_i            (run),
    .pc_i             (pc_q),
    .epc_i            (epc_q),
    .in_isr_i         (in_isr_q),
    .stall_i          (stall),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .int_req_i        (int_req),
    .eret_i           (eret),
    .halt_req_i       (halt_req),
    .pc_d_o           (sel_pc_d),
    .epc_we_o         (sel_epc_we),
    .epc_d_o          (sel_epc_d),
    .squash_o         (sel_squash),
    .fetch_o          (sel_fetch),
    .int_take_o       (sel_int_take),
    .isr_clr_o        (sel_isr_clr),
    .halt_o           (sel_halt),
    .align_err_o      (sel_align_err)
  );

  // FSM next state and register updates driven by the selected action.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    in_isr_d   = in_isr_q;
    addr_err_d = addr_err_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        pc_d = sel_pc_d;
        if (sel_halt) begin
          state_d    = StHalt;
          id_valid_d = 1'b0;
        end else if (sel_squash) begin
          id_valid_d = 1'b0;
        end else if (sel_fetch) begin
          id_valid_d = 1'b1;
          id_pc_d    = pc_q;
          id_instr_d = rom_dout;
        end
        if (sel_epc_we) epc_d = sel_epc_d;
        if (sel_int_take) begin
          in_isr_d = 1'b1;
        end else if (sel_isr_clr) begin
          in_isr_d = 1'b0;
        end
        addr_err_d = addr_err_q | sel_align_err;
      end
      StHalt: id_valid_d = 1'b0;
      default: state_d = StBoot;
    endcase
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= PC_RESET;
      epc_q      <= '0;
      id_pc_q    <= '0;
      id_instr_q <= NopInstr;
      id_valid_q <= 1'b0;
      in_isr_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      in_isr_q   <= in_isr_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign rom_sel  = run;
  assign rom_addr = pc_q[ROM_ADDR_BITS+1:2];
  assign int_ack  = sel_int_take;
  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;
  assign in_isr   = in_isr_q;
  assign epc      = epc_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized run against a model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, redirect_valid = 1'b0, int_req = 1'b0, eret = 1'b0, halt_req = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [9:0]  rom_addr;
  logic        rom_sel;
  logic [31:0] rom_dout;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        int_ack, in_isr, addr_err;
  logic [31:0] epc;

  logic [31:0] rom [1024];
  assign rom_dout = rom[rom_addr];

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Behavioural model state
  bit          m_booted, m_halted, m_in_isr, m_id_valid, m_addr_err;
  logic [31:0] m_pc, m_epc, m_id_pc, m_id_instr;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .int_req        (int_req),
    .eret           (eret),
    .halt_req       (halt_req),
    .rom_addr       (rom_addr),
    .rom_sel        (rom_sel),
    .rom_dout       (rom_dout),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .int_ack        (int_ack),
    .in_isr         (in_isr),
    .epc            (epc),
    .addr_err       (addr_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    stall = 0; redirect_valid = 0; redirect_pc = '0; int_req = 0; eret = 0; halt_req = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic model_reset;
    m_booted = 0; m_halted = 0; m_in_isr = 0; m_id_valid = 0; m_addr_err = 0;
    m_pc = 32'h0; m_epc = 32'h0; m_id_pc = 32'h0; m_id_instr = 32'h0;
  endtask

  function automatic bit bad_target(input logic [31:0] t);
`ifdef IFETCH_ALIGN_CHECK_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // One clock edge of the architectural fetch behaviour.
  task automatic model_edge;
    if (!m_booted) begin
      m_booted = 1;
    end else if (m_halted) begin
      m_id_valid = 0;
    end else if (halt_req) begin
      m_halted = 1; m_id_valid = 0;
    end else if (eret) begin
      if (bad_target(m_epc)) begin
        m_halted = 1; m_addr_err = 1; m_id_valid = 0;
      end else begin
        m_pc = m_epc; m_in_isr = 0; m_id_valid = 0;
      end
    end else if (int_req && !m_in_isr && !stall) begin
      m_epc = redirect_valid ? redirect_pc : m_pc;
      m_pc = 32'h0000_0800; m_in_isr = 1; m_id_valid = 0;
    end else if (redirect_valid) begin
      if (bad_target(redirect_pc)) begin
        m_halted = 1; m_addr_err = 1; m_id_valid = 0;
      end else begin
        m_pc = redirect_pc; m_id_valid = 0;
      end
    end else if (!stall) begin
      m_id_instr = rom[m_pc[11:2]];
      m_id_pc = m_pc; m_id_valid = 1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    clear_inputs();
    @(posedge clk);
    #1;
    n_total++; if (rom_sel !== 1'b0) $display("FAIL reset_rom_sel: got %b want 0", rom_sel); else n_pass++;
    n_total++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid: got %b want 0", id_valid); else n_pass++;
    n_total++; if (id_pc !== 32'h0) $display("FAIL reset_id_pc: got %h want 0", id_pc); else n_pass++;
    n_total++; if (id_instr !== 32'h0) $display("FAIL reset_id_instr: got %h want 0", id_instr); else n_pass++;
    n_total++; if (in_isr !== 1'b0) $display("FAIL reset_in_isr: got %b want 0", in_isr); else n_pass++;
    n_total++; if (epc !== 32'h0) $display("FAIL reset_epc: got %h want 0", epc); else n_pass++;
    n_total++; if (int_ack !== 1'b0) $display("FAIL reset_int_ack: got %b want 0", int_ack); else n_pass++;
    n_total++; if (addr_err !== 1'b0) $display("FAIL reset_addr_err: got %b want 0", addr_err); else n_pass++;
    rst = 0;
    n_total++; if (rom_sel !== 1'b0) $display("FAIL boot_rom_sel: got %b want 0", rom_sel); else n_pass++;
    tick();
    n_total++; if (rom_sel !== 1'b1) $display("FAIL run_rom_sel: got %b want 1", rom_sel); else n_pass++;
    n_total++; if (rom_addr !== 10'd0) $display("FAIL run_rom_addr: got %h want 0", rom_addr); else n_pass++;
    tick();
    n_total++; if (id_valid !== 1'b1) $display("FAIL fetch0_valid: got %b want 1", id_valid); else n_pass++;
    n_total++; if (id_pc !== 32'h0) $display("FAIL fetch0_pc: got %h want 0", id_pc); else n_pass++;
    n_total++; if (id_instr !== 32'h2001_0005) $display("FAIL fetch0_instr: got %h want 20010005", id_instr); else n_pass++;
    tick();
    n_total++; if (id_pc !== 32'h4) $display("FAIL fetch1_pc: got %h want 4", id_pc); else n_pass++;
    n_total++; if (id_instr !== 32'h2002_0007) $display("FAIL fetch1_instr: got %h want 20020007", id_instr); else n_pass++;
  endtask

  task automatic test_stall;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (id_pc !== 32'h4) $display("FAIL stall_id_pc: got %h want 4", id_pc); else n_pass++;
      n_total++; if (id_instr !== 32'h2002_0007) $display("FAIL stall_id_instr: got %h want 20020007", id_instr); else n_pass++;
      n_total++; if (rom_addr !== 10'd2) $display("FAIL stall_rom_addr: got %h want 2", rom_addr); else n_pass++;
    end
    stall = 0;
    tick();
    n_total++; if (id_pc !== 32'h8) $display("FAIL stall_resume_pc: got %h want 8", id_pc); else n_pass++;
    n_total++; if (id_instr !== rom[2]) $display("FAIL stall_resume_instr: got %h want %h", id_instr, rom[2]); else n_pass++;
  endtask

  task automatic test_redirect;
    tick();
    n_total++; if (rom_addr !== 10'h4) $display("FAIL redir_pre_addr: got %h want 4", rom_addr); else n_pass++;
    redirect_valid = 1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 0;
    n_total++; if (id_valid !== 1'b0) $display("FAIL redir_squash: got %b want 0", id_valid); else n_pass++;
    n_total++; if (rom_addr !== 10'h10) $display("FAIL redir_addr: got %h want 10", rom_addr); else n_pass++;
    tick();
    n_total++; if (id_pc !== 32'h40) $display("FAIL redir_id_pc: got %h want 40", id_pc); else n_pass++;
    n_total++; if (id_instr !== rom[16]) $display("FAIL redir_id_instr: got %h want %h", id_instr, rom[16]); else n_pass++;
  endtask

  task automatic test_interrupt;
    redirect_valid = 1; redirect_pc = 32'h20;
    tick();
    redirect_valid = 0;
    int_req = 1;
    #1;
    n_total++; if (int_ack !== 1'b1) $display("FAIL int_ack_comb: got %b want 1", int_ack); else n_pass++;
    tick();
    n_total++; if (int_ack !== 1'b0) $display("FAIL int_ack_pulse: got %b want 0", int_ack); else n_pass++;
    n_total++; if (in_isr !== 1'b1) $display("FAIL int_in_isr: got %b want 1", in_isr); else n_pass++;
    n_total++; if (epc !== 32'h20) $display("FAIL int_epc: got %h want 20", epc); else n_pass++;
    n_total++; if (id_valid !== 1'b0) $display("FAIL int_squash: got %b want 0", id_valid); else n_pass++;
    tick();
    n_total++; if (id_pc !== 32'h800) $display("FAIL int_vec_pc: got %h want 800", id_pc); else n_pass++;
    n_total++; if (epc !== 32'h20) $display("FAIL int_nested_epc: got %h want 20", epc); else n_pass++;
    n_total++; if (int_ack !== 1'b0) $display("FAIL int_nested_ack: got %b want 0", int_ack); else n_pass++;
    int_req = 0; eret = 1;
    tick();
    eret = 0;
    n_total++; if (in_isr !== 1'b0) $display("FAIL eret_in_isr: got %b want 0", in_isr); else n_pass++;
    n_total++; if (id_valid !== 1'b0) $display("FAIL eret_squash: got %b want 0", id_valid); else n_pass++;
    tick();
    n_total++; if (id_pc !== 32'h20) $display("FAIL eret_pc: got %h want 20", id_pc); else n_pass++;
    n_total++; if (id_instr !== rom[8]) $display("FAIL eret_instr: got %h want %h", id_instr, rom[8]); else n_pass++;
  endtask

  task automatic test_int_redirect;
    redirect_valid = 1; redirect_pc = 32'h100; int_req = 1;
    #1;
    n_total++; if (int_ack !== 1'b1) $display("FAIL intredir_ack: got %b want 1", int_ack); else n_pass++;
    tick();
    clear_inputs();
    n_total++; if (epc !== 32'h100) $display("FAIL intredir_epc: got %h want 100", epc); else n_pass++;
    tick();
    n_total++; if (id_pc !== 32'h800) $display("FAIL intredir_pc: got %h want 800", id_pc); else n_pass++;
    eret = 1;
    tick();
    eret = 0;
    tick();
    n_total++; if (id_pc !== 32'h100) $display("FAIL intredir_ret: got %h want 100", id_pc); else n_pass++;
  endtask

  task automatic test_int_defer;
    stall = 1; int_req = 1;
    #1;
    n_total++; if (int_ack !== 1'b0) $display("FAIL defer_ack_stall: got %b want 0", int_ack); else n_pass++;
    tick();
    tick();
    n_total++; if (in_isr !== 1'b0) $display("FAIL defer_in_isr: got %b want 0", in_isr); else n_pass++;
    stall = 0;
    #1;
    n_total++; if (int_ack !== 1'b1) $display("FAIL defer_ack_go: got %b want 1", int_ack); else n_pass++;
    tick();
    int_req = 0;
    n_total++; if (in_isr !== 1'b1) $display("FAIL defer_taken: got %b want 1", in_isr); else n_pass++;
    n_total++; if (epc !== 32'h104) $display("FAIL defer_epc: got %h want 104", epc); else n_pass++;
    eret = 1; int_req = 1;
    #1;
    n_total++; if (int_ack !== 1'b0) $display("FAIL eret_wins_ack: got %b want 0", int_ack); else n_pass++;
    tick();
    eret = 0;
    n_total++; if (in_isr !== 1'b0) $display("FAIL eret_wins_isr: got %b want 0", in_isr); else n_pass++;
    #1;
    n_total++; if (int_ack !== 1'b1) $display("FAIL after_eret_ack: got %b want 1", int_ack); else n_pass++;
    tick();
    int_req = 0;
    n_total++; if (in_isr !== 1'b1) $display("FAIL after_eret_isr: got %b want 1", in_isr); else n_pass++;
  endtask

  task automatic test_halt;
    halt_req = 1;
    tick();
    halt_req = 0;
    n_total++; if (rom_sel !== 1'b0) $display("FAIL halt_rom_sel: got %b want 0", rom_sel); else n_pass++;
    n_total++; if (id_valid !== 1'b0) $display("FAIL halt_id_valid: got %b want 0", id_valid); else n_pass++;
    eret = 1;
    repeat (3) tick();
    eret = 0; int_req = 1;
    #1;
    n_total++; if (int_ack !== 1'b0) $display("FAIL halt_int_ack: got %b want 0", int_ack); else n_pass++;
    n_total++; if (rom_sel !== 1'b0) $display("FAIL halt_stays: got %b want 0", rom_sel); else n_pass++;
    n_total++; if (id_valid !== 1'b0) $display("FAIL halt_stays_valid: got %b want 0", id_valid); else n_pass++;
    int_req = 0;
  endtask

  task automatic test_wrap;
    do_reset();
    tick();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 0;
    tick();
    n_total++; if (id_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_top_pc: got %h want fffffffc", id_pc); else n_pass++;
    n_total++; if (rom_addr !== 10'd0) $display("FAIL wrap_rom_addr: got %h want 0", rom_addr); else n_pass++;
    tick();
    n_total++; if (id_pc !== 32'h0) $display("FAIL wrap_pc: got %h want 0", id_pc); else n_pass++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    repeat (3) tick();
    int_req = 1;
    tick();
    int_req = 0;
    #2;
    rst = 1;
    #1;
    n_total++; if (in_isr !== 1'b0) $display("FAIL midrst_in_isr: got %b want 0", in_isr); else n_pass++;
    n_total++; if (epc !== 32'h0) $display("FAIL midrst_epc: got %h want 0", epc); else n_pass++;
    n_total++; if (rom_sel !== 1'b0) $display("FAIL midrst_rom_sel: got %b want 0", rom_sel); else n_pass++;
    n_total++; if (id_pc !== 32'h0) $display("FAIL midrst_id_pc: got %h want 0", id_pc); else n_pass++;
    n_total++; if (rom_addr !== 10'd0) $display("FAIL midrst_rom_addr: got %h want 0", rom_addr); else n_pass++;
    do_reset();
    n_total++; if (rom_sel !== 1'b0) $display("FAIL midrst_boot: got %b want 0", rom_sel); else n_pass++;
    tick();
    n_total++; if (rom_sel !== 1'b1) $display("FAIL midrst_run: got %b want 1", rom_sel); else n_pass++;
  endtask

  task automatic test_align;
    do_reset();
    tick();
    tick();
    redirect_valid = 1; redirect_pc = 32'h42;
    tick();
    redirect_valid = 0;
`ifdef IFETCH_ALIGN_CHECK_EN
    n_total++; if (addr_err !== 1'b1) $display("FAIL align_err: got %b want 1", addr_err); else n_pass++;
    n_total++; if (rom_sel !== 1'b0) $display("FAIL align_halt: got %b want 0", rom_sel); else n_pass++;
    n_total++; if (id_valid !== 1'b0) $display("FAIL align_valid: got %b want 0", id_valid); else n_pass++;
    repeat (3) tick();
    n_total++; if (addr_err !== 1'b1) $display("FAIL align_sticky: got %b want 1", addr_err); else n_pass++;
    n_total++; if (rom_sel !== 1'b0) $display("FAIL align_halt_stays: got %b want 0", rom_sel); else n_pass++;
`else
    n_total++; if (addr_err !== 1'b0) $display("FAIL align_err: got %b want 0", addr_err); else n_pass++;
    n_total++; if (rom_addr !== 10'h10) $display("FAIL align_trunc: got %h want 10", rom_addr); else n_pass++;
    tick();
    n_total++; if (id_pc !== 32'h42) $display("FAIL align_id_pc: got %h want 42", id_pc); else n_pass++;
    n_total++; if (id_instr !== rom[16]) $display("FAIL align_instr: got %h want %h", id_instr, rom[16]); else n_pass++;
`endif
  endtask

  task automatic test_random;
    bit exp_ack, exp_sel;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      model_reset();
      for (int c = 0; c < 120; c++) begin
        stall          = ($urandom_range(0, 3) == 0);
        redirect_valid = ($urandom_range(0, 7) == 0);
        redirect_pc    = $urandom & 32'h0000_FFFC;
        if ($urandom_range(0, 15) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
        int_req        = ($urandom_range(0, 7) == 0);
        eret           = ($urandom_range(0, 19) == 0);
        halt_req       = ($urandom_range(0, 299) == 0);
        #2;
        exp_sel = m_booted && !m_halted;
        exp_ack = exp_sel && !halt_req && !eret && int_req && !m_in_isr && !stall;
        n_total++; if (rom_sel !== exp_sel) $display("FAIL rnd_rom_sel: got %b want %b", rom_sel, exp_sel); else n_pass++;
        if (exp_sel) begin
          n_total++; if (rom_addr !== m_pc[11:2]) $display("FAIL rnd_rom_addr: got %h want %h", rom_addr, m_pc[11:2]); else n_pass++;
        end
        n_total++; if (int_ack !== exp_ack) $display("FAIL rnd_int_ack: got %b want %b", int_ack, exp_ack); else n_pass++;
        n_total++; if (id_valid !== m_id_valid) $display("FAIL rnd_id_valid: got %b want %b", id_valid, m_id_valid); else n_pass++;
        if (m_id_valid) begin
          n_total++; if (id_pc !== m_id_pc) $display("FAIL rnd_id_pc: got %h want %h", id_pc, m_id_pc); else n_pass++;
          n_total++; if (id_instr !== m_id_instr) $display("FAIL rnd_id_instr: got %h want %h", id_instr, m_id_instr); else n_pass++;
        end
        n_total++; if (in_isr !== m_in_isr) $display("FAIL rnd_in_isr: got %b want %b", in_isr, m_in_isr); else n_pass++;
        n_total++; if (epc !== m_epc) $display("FAIL rnd_epc: got %h want %h", epc, m_epc); else n_pass++;
        n_total++; if (addr_err !== m_addr_err) $display("FAIL rnd_addr_err: got %b want %b", addr_err, m_addr_err); else n_pass++;
        @(posedge clk);
        model_edge();
        #1;
      end
    end
    clear_inputs();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[0] = 32'h2001_0005;
    rom[1] = 32'h2002_0007;
    test_reset();
    test_stall();
    test_redirect();
    test_interrupt();
    test_int_redirect();
    test_int_defer();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_align();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
